ghost_collision_ctrl: RTL and testbench

- Consumes the positions produced by the four ghost controllers and the player controller.
- Detects player/ghost contact on each movement step and manages the life counter.
- Sequences a freeze, then a respawn pulse that restarts all actors at their spawn tiles, and latches game over.
- Sits directly downstream of the ghost controllers and upstream of the display/score logic.

---
 rtl/ghost_collision_ctrl.sv | 134 +++++++++++++
 tb/tb_ghost_collision_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ghost_collision_ctrl.sv
// Player/ghost collision detector and life/respawn sequencer.
// Detects same-tile and swap contacts on each movement step, then freezes, respawns or ends the game.
module ghost_collision_ctrl #(
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int INIT_LIVES    = 3,
  parameter int FREEZE_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [X_W-1:0]   player_x,
  input  logic [Y_W-1:0]   player_y,
  input  logic [4*X_W-1:0] ghost_x,
  input  logic [4*Y_W-1:0] ghost_y,
  output logic [2:0]       lives,
  output logic             hit,
  output logic [1:0]       hit_ghost,
  output logic             freeze,
  output logic             actor_reset_n,
  output logic             game_over
);

  localparam int CNT_W = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FRZ_LOAD = CNT_W'(FREEZE_CYCLES - 1);
  localparam logic [2:0] LIVES_RST = 3'(INIT_LIVES);

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    FREEZE  = 2'd1,
    RESPAWN = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frz_cnt;
  logic             prev_valid;
  logic [X_W-1:0]   prev_px;
  logic [Y_W-1:0]   prev_py;
  logic [4*X_W-1:0] prev_gx;
  logic [4*Y_W-1:0] prev_gy;
  logic [3:0]       coll_p0;

  function automatic logic [1:0] first_hit(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Stage p0: per-ghost contact, either sharing a tile or having swapped tiles since the last step
  always_comb begin
    coll_p0 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      coll_p0[i] =
        ((ghost_x[i*X_W +: X_W] == player_x) && (ghost_y[i*Y_W +: Y_W] == player_y)) ||
        (prev_valid &&
         (ghost_x[i*X_W +: X_W] == prev_px) && (ghost_y[i*Y_W +: Y_W] == prev_py) &&
         (player_x == prev_gx[i*X_W +: X_W]) && (player_y == prev_gy[i*Y_W +: Y_W]));
    end
  end

  // Stage p1: registered control and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= PLAY;
      frz_cnt       <= '0;
      lives         <= LIVES_RST;
      hit           <= 1'b0;
      hit_ghost     <= 2'd0;
      freeze        <= 1'b0;
      actor_reset_n <= 1'b1;
      game_over     <= 1'b0;
      prev_valid    <= 1'b0;
      prev_px       <= '0;
      prev_py       <= '0;
      prev_gx       <= '0;
      prev_gy       <= '0;
    end else begin
      hit <= 1'b0;
      unique case (state)
        PLAY: begin
          if (step) begin
            prev_valid <= 1'b1;
            prev_px    <= player_x;
            prev_py    <= player_y;
            prev_gx    <= ghost_x;
            prev_gy    <= ghost_y;
            if (|coll_p0) begin
              hit       <= 1'b1;
              hit_ghost <= first_hit(coll_p0);
              lives     <= sat_dec(lives);
              freeze    <= 1'b1;
              // The last life ends the game without a respawn pulse
              if (lives <= 3'd1) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state   <= FREEZE;
                frz_cnt <= FRZ_LOAD;
              end
            end
          end
        end
        FREEZE: begin
          if (frz_cnt == '0) begin
            state         <= RESPAWN;
            actor_reset_n <= 1'b0;
          end else begin
            frz_cnt <= frz_cnt - 1'b1;
          end
        end
        RESPAWN: begin
          state         <= PLAY;
          actor_reset_n <= 1'b1;
          freeze        <= 1'b0;
          prev_valid    <= 1'b0;
        end
        OVER: begin
          freeze    <= 1'b1;
          game_over <= 1'b1;
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Randomized + directed bench for ghost_collision_ctrl against a cycle-count reference model.
module tb_ghost_collision_ctrl;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int INIT_LIVES = 3;
  localparam int FC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step = 1'b0;
  logic [X_W-1:0] px = '0;
  logic [Y_W-1:0] py = '0;
  logic [X_W-1:0] gx [4];
  logic [Y_W-1:0] gy [4];
  logic [4*X_W-1:0] ghost_x;
  logic [4*Y_W-1:0] ghost_y;
  logic [2:0] lives;
  logic hit, freeze, actor_reset_n, game_over;
  logic [1:0] hit_ghost;

  assign ghost_x = {gx[3], gx[2], gx[1], gx[0]};
  assign ghost_y = {gy[3], gy[2], gy[1], gy[0]};

  ghost_collision_ctrl #(.X_W(X_W), .Y_W(Y_W), .INIT_LIVES(INIT_LIVES), .FREEZE_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .step(step), .player_x(px), .player_y(py),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .lives(lives), .hit(hit), .hit_ghost(hit_ghost),
    .freeze(freeze), .actor_reset_n(actor_reset_n), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: rec counts cycles since the last hit while recovering (-1 = not recovering).
  int m_lives, m_hg, rec, first;
  bit m_hit, m_over, m_pv;
  int mpx, mpy;
  int mgx [4];
  int mgy [4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lives = INIT_LIVES; m_hit = 0; m_hg = 0; m_over = 0; rec = -1; m_pv = 0;
      mpx = 0; mpy = 0;
      for (int i = 0; i < 4; i++) begin mgx[i] = 0; mgy[i] = 0; end
    end else begin
      m_hit = 0;
      if (rec >= 0) begin
        rec++;
        if (rec > FC) begin rec = -1; m_pv = 0; end
      end else if (!m_over && step) begin
        first = -1;
        for (int i = 0; i < 4; i++) begin
          if (first < 0 &&
              ((int'(gx[i]) == int'(px) && int'(gy[i]) == int'(py)) ||
               (m_pv && int'(gx[i]) == mpx && int'(gy[i]) == mpy &&
                int'(px) == mgx[i] && int'(py) == mgy[i])))
            first = i;
        end
        if (first >= 0) begin
          m_hit = 1; m_hg = first;
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_over = 1; else rec = 0;
        end
        mpx = int'(px); mpy = int'(py);
        for (int i = 0; i < 4; i++) begin mgx[i] = int'(gx[i]); mgy[i] = int'(gy[i]); end
        m_pv = 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("lives", int'(lives), m_lives);
    chk("hit", int'(hit), int'(m_hit));
    chk("hit_ghost", int'(hit_ghost), m_hg);
    chk("freeze", int'(freeze), int'(m_over || rec >= 0));
    chk("actor_reset_n", int'(actor_reset_n), int'(rec != FC));
    chk("game_over", int'(game_over), int'(m_over));
  end

  task automatic tick(input logic s);
    step = s;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic place(input int i, input int x, input int y);
    gx[i] = X_W'(x);
    gy[i] = Y_W'(y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    place(0, 300, 300); place(1, 500, 400); place(2, 520, 400); place(3, 540, 400);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lives", int'(lives), 3);
    chk("rst_freeze", int'(freeze), 0);
    chk("rst_arn", int'(actor_reset_n), 1);
    chk("rst_over", int'(game_over), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Same tile, first without step, then with step
    px = 600; py = 320; place(2, 600, 320);
    tick(0);
    chk("nostep_hit", int'(hit), 0);
    tick(1);
    chk("tile_hit", int'(hit), 1);
    chk("tile_ghost", int'(hit_ghost), 2);
    chk("tile_lives", int'(lives), 2);
    chk("tile_freeze", int'(freeze), 1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("frz_hit", int'(hit), 0);
      chk("frz_lives", int'(lives), 2);
      chk("frz_arn", int'(actor_reset_n), (k == 4) ? 0 : 1);
      chk("frz_freeze", int'(freeze), (k == 5) ? 0 : 1);
    end

    // Swap crossing
    place(2, 500, 400); place(1, 520, 400); place(3, 540, 400);
    px = 100; py = 40; place(0, 120, 40);
    tick(1);
    chk("swapA_hit", int'(hit), 0);
    px = 120; place(0, 100, 40);
    tick(1);
    chk("swapB_hit", int'(hit), 1);
    chk("swapB_ghost", int'(hit_ghost), 0);
    chk("swapB_lives", int'(lives), 1);
    repeat (5) tick(1);
    chk("swap_resume", int'(freeze), 0);
    px = 100; place(0, 120, 40);
    tick(1);
    chk("post_respawn_hit", int'(hit), 0);
    chk("post_respawn_lives", int'(lives), 1);

    // Two ghosts on the player tile, last life
    place(0, 300, 300); place(1, 100, 40); place(3, 100, 40);
    tick(1);
    chk("multi_hit", int'(hit), 1);
    chk("multi_ghost", int'(hit_ghost), 1);
    chk("multi_lives", int'(lives), 0);
    chk("over_flag", int'(game_over), 1);
    repeat (6) begin
      tick(1);
      chk("over_hit", int'(hit), 0);
      chk("over_arn", int'(actor_reset_n), 1);
      chk("over_freeze", int'(freeze), 1);
    end

    // Async reset in the middle of FREEZE
    reset = 1'b0;
    #1;
    chk("rst2_lives", int'(lives), 3);
    chk("rst2_over", int'(game_over), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(1);
    chk("hit3", int'(hit), 1);
    chk("hit3_lives", int'(lives), 2);
    tick(0);
    tick(0);
    reset = 1'b0;
    #1;
    chk("midfrz_lives", int'(lives), 3);
    chk("midfrz_freeze", int'(freeze), 0);
    chk("midfrz_arn", int'(actor_reset_n), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Random play on a small grid so contacts and swaps are frequent
    for (int n = 0; n < 4000; n++) begin
      px = X_W'(20 * $urandom_range(0, 2));
      py = Y_W'(20 * $urandom_range(0, 2));
      for (int i = 0; i < 4; i++) place(i, 20 * $urandom_range(0, 2), 20 * $urandom_range(0, 2));
      tick(logic'($urandom_range(0, 1)));
      if ((m_over && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
